// File: rtl/ar_arbiter.sv
// Two-to-one AXI read-channel arbiter: round-robin AR grant with the grant index
// prepended to the slave ARID, ID-based R routing and per-master burst throttling.
module ar_arbiter #(
    parameter int BusWidth       = 32,
    parameter int tagbits        = 1,
    parameter int MaxOutstanding = 4,
    localparam int W             = BusWidth + 17 + tagbits
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [W-1:0]        M0_AR,
    input  logic                M0_ARVALID,
    output logic                M0_ARREADY,
    input  logic [W-1:0]        M1_AR,
    input  logic                M1_ARVALID,
    output logic                M1_ARREADY,
    output logic [W:0]          S_AR,
    output logic                S_ARVALID,
    input  logic                S_ARREADY,
    input  logic [tagbits:0]    S_RID,
    input  logic [BusWidth-1:0] S_RDATA,
    input  logic [1:0]          S_RRESP,
    input  logic                S_RLAST,
    input  logic                S_RVALID,
    output logic                S_RREADY,
    output logic [tagbits-1:0]  M_RID,
    output logic [BusWidth-1:0] M_RDATA,
    output logic [1:0]          M_RRESP,
    output logic                M_RLAST,
    output logic                M0_RVALID,
    output logic                M1_RVALID,
    input  logic                M0_RREADY,
    input  logic                M1_RREADY
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MAX_CNT  = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CNT_ONE  = CntW'(1);
    localparam logic [CntW-1:0] CNT_ZERO = CntW'(0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [W:0]             s_ar_q, s_ar_d;
    logic                   last_grant_q, last_grant_d;
    logic [1:0][CntW-1:0]   cnt_q, cnt_d;

    logic [1:0]             elig;
    logic                   winner;
    logic [1:0]             inc;
    logic [1:0]             dec;
    logic                   sel;
    logic                   r_done;

    // AR state machine: eligibility, round-robin winner, grant and slave handshake
    always_comb begin
        state_d      = state_q;
        s_ar_d       = s_ar_q;
        last_grant_d = last_grant_q;
        inc          = 2'b00;
        M0_ARREADY   = 1'b0;
        M1_ARREADY   = 1'b0;
        elig[0]      = M0_ARVALID && (cnt_q[0] < MAX_CNT);
        elig[1]      = M1_ARVALID && (cnt_q[1] < MAX_CNT);
        // On contention the master that did not win last time goes first
        winner       = (elig == 2'b11) ? ~last_grant_q : elig[1];
        case (state_q)
            ST_IDLE: begin
                if (!ARESET && (elig != 2'b00)) begin
                    M0_ARREADY   = ~winner;
                    M1_ARREADY   = winner;
                    s_ar_d       = winner ? {1'b1, M1_AR} : {1'b0, M0_AR};
                    last_grant_d = winner;
                    state_d      = ST_SEND;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (S_ARREADY) begin
                    inc[last_grant_q] = 1'b1;
                    state_d           = ST_IDLE;
                end else begin
                    state_d           = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // R-channel routing by the grant bit carried in the top of RID
    always_comb begin
        sel       = S_RID[tagbits];
        M_RID     = S_RID[tagbits-1:0];
        M_RDATA   = S_RDATA;
        M_RRESP   = S_RRESP;
        M_RLAST   = S_RLAST;
        M0_RVALID = S_RVALID & ~sel;
        M1_RVALID = S_RVALID & sel;
        S_RREADY  = sel ? M1_RREADY : M0_RREADY;
        r_done    = S_RVALID & S_RREADY & S_RLAST;
    end

    // Outstanding-burst counters; a completion at zero is a spurious RLAST and is dropped
    always_comb begin
        cnt_d = cnt_q;
        dec   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            dec[i] = r_done && (sel == i[0]);
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec[i] && !inc[i] && (cnt_q[i] != CNT_ZERO)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State, slave bundle, priority and counter registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            s_ar_q       <= '0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            s_ar_q       <= s_ar_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign S_AR      = s_ar_q;
    assign S_ARVALID = (state_q == ST_SEND);

endmodule

// File: doc/ar_arbiter.md
# ar_arbiter

Two-to-one AXI read-channel arbiter. It shares one slave read port between two read masters. Round-robin arbitration is applied on the AR channel. The grant index is appended as the MSB of the slave-side ARID, and R beats are routed back to the owning master by that bit. A per-master outstanding-burst counter throttles each master.

## Interface
Parameters:
- BusWidth, 32, address/data width
- tagbits, 1, master-side ID width
- MaxOutstanding, 4, max un-completed bursts per master (1..15)

AR bundle packing, MSB to LSB: {ARID, ARADDR, ARLEN[3:0], ARSIZE[1:0], ARBURST[1:0], ARLOCK[1:0], ARCACHE[3:0], ARPROT[2:0]}. Width is W = BusWidth+17+tagbits.

Ports (name, direction, width, meaning):
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- M0_AR  in  W  master 0 AR bundle
- M0_ARVALID  in  1  master 0 request valid
- M0_ARREADY  out  1  master 0 request accepted
- M1_AR  in  W  master 1 AR bundle
- M1_ARVALID  in  1  master 1 request valid
- M1_ARREADY  out  1  master 1 request accepted
- S_AR  out  W+1  slave AR bundle, ARID = {grant, master ARID}
- S_ARVALID  out  1  slave request valid
- S_ARREADY  in  1  slave accepts request
- S_RID  in  tagbits+1  slave read ID
- S_RDATA  in  BusWidth  slave read data
- S_RRESP  in  2  slave read response
- S_RLAST  in  1  last beat of burst
- S_RVALID  in  1  slave beat valid
- S_RREADY  out  1  ready to slave
- M_RID  out  tagbits  S_RID[tagbits-1:0], broadcast
- M_RDATA  out  BusWidth  S_RDATA, broadcast
- M_RRESP  out  2  S_RRESP, broadcast
- M_RLAST  out  1  S_RLAST, broadcast
- M0_RVALID  out  1  beat for master 0
- M1_RVALID  out  1  beat for master 1
- M0_RREADY  in  1  master 0 ready
- M1_RREADY  in  1  master 1 ready

## Operation
- AR state machine, two states:
  - IDLE: S_ARVALID=0. A master is eligible when its ARVALID=1 and its count < MaxOutstanding. If both are eligible, the master not in last_grant wins. If one is eligible, it wins. The winner's ARREADY=1, combinational, IDLE only. On that handshake edge: S_AR <= {winner, winner bundle}, last_grant <= winner, go to SEND.
  - SEND: S_ARVALID=1, S_AR held stable, both M*_ARREADY=0. On S_ARVALID&S_ARREADY: count[last_grant] += 1, go to IDLE.
- R path is purely combinational:
  - sel = S_RID[tagbits].
  - M0_RVALID = S_RVALID&~sel; M1_RVALID = S_RVALID&sel.
  - S_RREADY = sel ? M1_RREADY : M0_RREADY.
- Completion: on S_RVALID&S_RREADY&S_RLAST, count[sel] -= 1.
- Counters:
  - width clog2(MaxOutstanding+1).
  - Increment and decrement on the same master in one cycle leaves the count unchanged.
  - Decrement at 0 holds 0 (spurious RLAST is ignored).
  - Increment never exceeds MaxOutstanding because grant is gated.

## Timing
- Reset values: state IDLE, S_AR=0, S_ARVALID=0, counts 0, last_grant=1 (master 0 has first priority).
  - M*_ARREADY=0 during reset.
  - R outputs follow their inputs combinationally. S_RREADY follows M*_RREADY.
- Latency: M handshake at edge k puts S_ARVALID=1 in cycle k+1. The earliest slave handshake is edge k+1. The next M*_ARREADY can assert in cycle k+2.
- Maximum AR throughput: one burst per 2 cycles.
- While S_ARVALID=1 and S_ARREADY=0, S_AR is held unchanged indefinitely, per the AXI rule.
- Masters must hold ARVALID/AR until ARREADY. Dropping ARVALID before grant withdraws the request with no side effect.
- Reset asserted mid-operation (SEND or bursts in flight): everything returns to reset values on the next edge. Outstanding bursts are forgotten, so the slave must be reset together with this block.
- No combinational path exists from M*_ARVALID to S_ARVALID. The only combinational paths are R-channel and M*_ARREADY.

## Test plan
- Single request: M0_ARVALID with ADDR=0x100, ID=1, S_ARREADY=1 -> M0_ARREADY in cycle 0; S_ARVALID cycle 1 with ARID=2'b01, ADDR=0x100; back to IDLE cycle 2.
- Contention: both valid continuously, S_ARREADY=1 -> grants M0,M1,M0,M1 on every other cycle; S ARID MSB alternates 0,1,0,1.
- Backpressure: S_ARREADY=0 for 5 cycles in SEND -> S_AR stable and both M*_ARREADY=0 throughout; grant completes on the cycle S_ARREADY rises.
- Throttle: MaxOutstanding=4, M0 issues 4 bursts with no RLAST -> 5th request stalled, M1 still granted. One RLAST beat with RID MSB=0 -> M0 granted on the next IDLE.
- R routing: S_RID=2'b10 with RVALID, M1_RREADY=0 -> M1_RVALID=1, M0_RVALID=0, S_RREADY=0. With M1_RREADY=1, RLAST and a simultaneous M1 AR handshake -> count[1] unchanged.
- Reset in SEND with count[0]=3 -> next cycle S_ARVALID=0, counts 0, and M0 wins the first post-reset contention.
